// File: rtl/rack_fixed_pkg.sv
// Q16.16 fixed-point helpers and the twitch-filter FSM encoding.
// Shared by spike_twitch_force and fx_mul_sat.
package rack_fixed_pkg;

  localparam logic signed [31:0] FX_ONE = 32'sh0001_0000;
  localparam logic signed [31:0] FX_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] FX_MIN = 32'sh8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_SUM,
    ST_OUT
  } fsm_state_t;

  function automatic logic fits32(
    input logic signed [33:0] v
  );
    return (v[33:31] == 3'b000) ||
           (v[33:31] == 3'b111);
  endfunction

  function automatic logic signed [31:0] sat32(
    input logic signed [33:0] v
  );
    if (fits32(v)) return v[31:0];
    return v[33] ? FX_MIN : FX_MAX;
  endfunction

endpackage

// File: rtl/spike_twitch_force_mul.sv
// Combinational signed Q16.16 multiply, result bits [47:16] (floor).
// Ports: a, b operands; y saturated product; sat high when clamped.
module fx_mul_sat
  import rack_fixed_pkg::*;
(
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] y,
  output logic               sat
);

  logic signed [47:0] ps;

  always_comb begin
    ps  = 48'((64'(a) * 64'(b)) >>> 16);
    sat = !((ps[47:31] == '0) ||
            (ps[47:31] == '1));
    y   = ps[31:0];
    if (sat) y = ps[47] ? FX_MIN : FX_MAX;
  end

endmodule

// File: rtl/spike_twitch_force.sv
// Spike train -> muscle force via f = c1*f1 + c2*f2 + K*s, one shared mult.
// Ports: clk, reset_global, spike/tick (async), coef_c1/c2, gain_k in;
//        f_out, f_valid, spike_cnt_last, busy, sat_flag, overrun out.
module spike_twitch_force
  import rack_fixed_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit CLAMP_NEG   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_global,
  input  logic               spike,
  input  logic               tick,
  input  logic signed [31:0] coef_c1,
  input  logic signed [31:0] coef_c2,
  input  logic signed [31:0] gain_k,
  output logic signed [31:0] f_out,
  output logic               f_valid,
  output logic [CNT_W-1:0]   spike_cnt_last,
  output logic               busy,
  output logic               sat_flag,
  output logic               overrun
);

  logic [SYNC_STAGES-1:0] spike_sync;
  logic [SYNC_STAGES-1:0] tick_sync;
  logic spike_prev, tick_prev;
  logic spike_rise, tick_rise;

  logic [CNT_W-1:0] cnt, s_r;
  fsm_state_t state, state_d;

  logic signed [31:0] c1_r, c2_r, k_r;
  logic signed [31:0] f1, f2;
  logic signed [31:0] p1, p2, p3;
  logic signed [31:0] mul_a, mul_b, mul_y;
  logic signed [31:0] s_fx, sum_sat, r_next;
  logic signed [33:0] acc;
  logic mul_sat, mul_stage, sum_fits;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      spike_sync <= '0;
      tick_sync  <= '0;
      spike_prev <= 1'b0;
      tick_prev  <= 1'b0;
      spike_rise <= 1'b0;
      tick_rise  <= 1'b0;
    end else begin
      spike_sync <= (spike_sync << 1) |
                    SYNC_STAGES'(spike);
      tick_sync  <= (tick_sync << 1) |
                    SYNC_STAGES'(tick);
      spike_prev <= spike_sync[SYNC_STAGES-1];
      tick_prev  <= tick_sync[SYNC_STAGES-1];
      spike_rise <= spike_sync[SYNC_STAGES-1] &
                    ~spike_prev;
      tick_rise  <= tick_sync[SYNC_STAGES-1] &
                    ~tick_prev;
    end
  end

  // A spike coincident with the closing tick opens the new window.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      cnt <= '0;
    end else if (tick_rise && state == ST_IDLE) begin
      cnt <= spike_rise ? CNT_W'(1) : '0;
    end else if (spike_rise && !(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) state <= ST_IDLE;
    else              state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (tick_rise) state_d = ST_M1;
      ST_M1:   state_d = ST_M2;
      ST_M2:   state_d = ST_M3;
      ST_M3:   state_d = ST_SUM;
      ST_SUM:  state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Counts beyond 32767 do not fit a signed Q16.16
  // operand; pin them at the largest integer.
  always_comb begin
    if (32'(s_r) > 32'd32767) s_fx = 32'sh7FFF_0000;
    else                      s_fx = 32'(s_r) << 16;
  end

  always_comb begin
    mul_a = c1_r;
    mul_b = f1;
    unique case (state)
      ST_M2: begin
        mul_a = c2_r;
        mul_b = f2;
      end
      ST_M3: begin
        mul_a = k_r;
        mul_b = s_fx;
      end
      default: ;
    endcase
  end

  fx_mul_sat u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .y   (mul_y),
    .sat (mul_sat)
  );

  always_comb begin
    mul_stage = (state == ST_M1) ||
                (state == ST_M2) ||
                (state == ST_M3);
    acc      = 34'(p1) + 34'(p2) + 34'(p3);
    sum_fits = fits32(acc);
    sum_sat  = sat32(acc);
    r_next   = sum_sat;
    if (CLAMP_NEG && sum_sat[31]) r_next = '0;
  end

  // f_out/f_valid are loaded leaving SUM so the new
  // value is on the pins during the OUT cycle.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      c1_r           <= '0;
      c2_r           <= '0;
      k_r            <= '0;
      s_r            <= '0;
      p1             <= '0;
      p2             <= '0;
      p3             <= '0;
      f1             <= '0;
      f2             <= '0;
      f_out          <= '0;
      f_valid        <= 1'b0;
      spike_cnt_last <= '0;
      sat_flag       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      f_valid <= 1'b0;
      if (tick_rise && busy) overrun <= 1'b1;
      if ((mul_stage && mul_sat) ||
          (state == ST_SUM && !sum_fits))
        sat_flag <= 1'b1;
      unique case (state)
        ST_IDLE: if (tick_rise) begin
          c1_r           <= coef_c1;
          c2_r           <= coef_c2;
          k_r            <= gain_k;
          s_r            <= cnt;
          spike_cnt_last <= cnt;
        end
        ST_M1: p1 <= mul_y;
        ST_M2: p2 <= mul_y;
        ST_M3: p3 <= mul_y;
        ST_SUM: begin
          f_out   <= r_next;
          f_valid <= 1'b1;
        end
        ST_OUT: begin
          f2 <= f1;
          f1 <= f_out;
        end
        default: ;
      endcase
    end
  end

endmodule
